// File: rtl/pad_pok_monitor_if.sv
// Pad power-OK monitor bus: raw pad status in, filtered status, sticky drop events and interrupt out.
interface pad_pok_monitor_if #(
  parameter int unsigned NIoBanks = 4,
  parameter int unsigned PokW     = 1
);
  logic [NIoBanks*PokW-1:0] pad_pok_i;
  logic [NIoBanks-1:0]      bank_ok_o;
  logic                     all_ok_o;
  logic [NIoBanks-1:0]      drop_status_o;
  logic [NIoBanks-1:0]      drop_clr_i;
  logic [NIoBanks-1:0]      drop_en_i;
  logic                     irq_o;

  modport slave (
    input  pad_pok_i, drop_clr_i, drop_en_i,
    output bank_ok_o, all_ok_o, drop_status_o, irq_o
  );

  modport master (
    output pad_pok_i, drop_clr_i, drop_en_i,
    input  bank_ok_o, all_ok_o, drop_status_o, irq_o
  );
endinterface

// File: rtl/pad_pok_monitor.sv
// Synchronises and debounces per-bank pad power-OK, latches sticky power-drop
// events and raises a maskable interrupt.
module pad_pok_monitor #(
  parameter int unsigned NIoBanks     = 4,
  parameter int unsigned PokW         = 1,
  parameter int unsigned FilterCycles = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pad_pok_monitor_if.slave  bus
);
  localparam int unsigned CntW   = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    ST_DOWN = 2'd0,
    ST_RISE = 2'd1,
    ST_UP   = 2'd2,
    ST_FALL = 2'd3
  } state_e;

  logic [NIoBanks-1:0] w_raw;
  logic [NIoBanks-1:0] r_sync1;
  logic [NIoBanks-1:0] r_sync2;
  state_e              r_state     [NIoBanks];
  state_e              w_state_nxt [NIoBanks];
  logic [CntW-1:0]     r_cnt       [NIoBanks];
  logic [CntW-1:0]     w_cnt_nxt   [NIoBanks];
  logic [NIoBanks-1:0] w_ok_nxt;
  logic [NIoBanks-1:0] r_bank_ok;
  logic [NIoBanks-1:0] r_bank_ok_d;
  logic [NIoBanks-1:0] w_drop_nxt;
  logic [NIoBanks-1:0] r_drop;
  logic                r_irq;

  // A bank is raw-OK only when every pad bit of that bank reports OK.
  always_comb begin
    w_raw = '0;
    for (int b = 0; b < NIoBanks; b++) begin
      w_raw[b] = &bus.pad_pok_i[b*PokW +: PokW];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NIoBanks; b++) begin
        r_state[b] <= ST_DOWN;
        r_cnt[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < NIoBanks; b++) begin
        r_state[b] <= w_state_nxt[b];
        r_cnt[b]   <= w_cnt_nxt[b];
      end
    end
  end

  // Debounce: a level change must hold for FilterCycles further samples after entry.
  always_comb begin
    for (int b = 0; b < NIoBanks; b++) begin
      w_state_nxt[b] = r_state[b];
      w_cnt_nxt[b]   = r_cnt[b];
      unique case (r_state[b])
        ST_DOWN: begin
          if (r_sync2[b]) begin
            w_state_nxt[b] = ST_RISE;
            w_cnt_nxt[b]   = CntOne;
          end
        end
        ST_RISE: begin
          if (!r_sync2[b]) begin
            w_state_nxt[b] = ST_DOWN;
            w_cnt_nxt[b]   = '0;
          end else if (r_cnt[b] == CntMax) begin
            w_state_nxt[b] = ST_UP;
            w_cnt_nxt[b]   = '0;
          end else begin
            w_cnt_nxt[b]   = r_cnt[b] + CntOne;
          end
        end
        ST_UP: begin
          if (!r_sync2[b]) begin
            w_state_nxt[b] = ST_FALL;
            w_cnt_nxt[b]   = CntOne;
          end
        end
        ST_FALL: begin
          if (r_sync2[b]) begin
            w_state_nxt[b] = ST_UP;
            w_cnt_nxt[b]   = '0;
          end else if (r_cnt[b] == CntMax) begin
            w_state_nxt[b] = ST_DOWN;
            w_cnt_nxt[b]   = '0;
          end else begin
            w_cnt_nxt[b]   = r_cnt[b] + CntOne;
          end
        end
        default: begin
          w_state_nxt[b] = ST_DOWN;
          w_cnt_nxt[b]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_ok_nxt = '0;
    for (int b = 0; b < NIoBanks; b++) begin
      w_ok_nxt[b] = (r_state[b] == ST_UP) || (r_state[b] == ST_FALL);
    end
  end

  // Drop event on a filtered 1->0 edge; a coincident clear loses to the set.
  assign w_drop_nxt = (r_drop & ~bus.drop_clr_i) | (r_bank_ok_d & ~r_bank_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bank_ok   <= '0;
      r_bank_ok_d <= '0;
      r_drop      <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_bank_ok   <= w_ok_nxt;
      r_bank_ok_d <= r_bank_ok;
      r_drop      <= w_drop_nxt;
      r_irq       <= |(r_drop & bus.drop_en_i);
    end
  end

  assign bus.bank_ok_o     = r_bank_ok;
  assign bus.all_ok_o      = &r_bank_ok;
  assign bus.drop_status_o = r_drop;
  assign bus.irq_o         = r_irq;

  a_outputs_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({r_bank_ok, r_drop, r_irq}));

endmodule
